// File: rtl/decode_stage.sv
// RV32I decode stage: instruction/regfile read in, registered ALU operation and
// operands out over a valid/ready handshake with stall and flush.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_LT  = 4'd3,
    ALU_LTU = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_OR  = 4'd8,
    ALU_AND = 4'd9,
    ALU_EQ  = 4'd10,
    ALU_NE  = 4'd11,
    ALU_GE  = 4'd12,
    ALU_GEU = 4'd13,
    ALU_IMM = 4'd14,
    ALU_PC4 = 4'd15
  } alu_operation_t;
endpackage

module decode_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  input  logic [31:0]          rs1_data,
  input  logic [31:0]          rs2_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output alu_operation_t       out_operation,
  output logic [31:0]          out_lhs,
  output logic [31:0]          out_rhs,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_rs2_data,
  output logic [4:0]           out_rd,
  output logic                 out_reg_write,
  output logic                 out_branch,
  output logic                 out_jal,
  output logic                 out_jalr,
  output logic                 out_load,
  output logic                 out_store,
  output logic [2:0]           out_funct3,
  output logic                 out_illegal
);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic [4:0]     rd;
  logic [31:0]    rs1_val, rs2_val;
  logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  alu_operation_t d_op;
  logic [31:0]    d_lhs, d_rhs, d_imm;
  logic           d_writes, d_branch, d_jal, d_jalr, d_load, d_store, d_illegal;
  logic           accept;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd       = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // x0 is hardwired to zero whatever the register file returns
  assign rs1_val = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'd0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  function automatic alu_operation_t arith_op(input logic [2:0] f3, input logic alt);
    alu_operation_t op;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_LT;
      3'd3:    op = ALU_LTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    d_op      = ALU_ADD;
    d_lhs     = 32'd0;
    d_rhs     = 32'd0;
    d_imm     = 32'd0;
    d_writes  = 1'b0;
    d_branch  = 1'b0;
    d_jal     = 1'b0;
    d_jalr    = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      7'h33: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          d_op     = arith_op(funct3, funct7[5]);
          d_lhs    = rs1_val;
          d_rhs    = rs2_val;
          d_writes = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      7'h13: begin
        d_imm = imm_i;
        if ((funct3 == 3'd1 && funct7 != 7'h00) ||
            (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)) begin
          d_illegal = 1'b1;
        end else begin
          // shifts take only the shamt field; bit 30 picks arithmetic right shift
          d_op     = arith_op(funct3, funct3 == 3'd5 && funct7[5]);
          d_lhs    = rs1_val;
          d_rhs    = (funct3 == 3'd1 || funct3 == 3'd5) ? {27'd0, imm_i[4:0]} : imm_i;
          d_writes = 1'b1;
        end
      end
      7'h37: begin
        d_op     = ALU_IMM;
        d_rhs    = imm_u;
        d_imm    = imm_u;
        d_writes = 1'b1;
      end
      7'h17: begin
        d_lhs    = in_pc;
        d_rhs    = imm_u;
        d_imm    = imm_u;
        d_writes = 1'b1;
      end
      7'h6F: begin
        d_op     = ALU_PC4;
        d_lhs    = in_pc;
        d_rhs    = imm_j;
        d_imm    = imm_j;
        d_writes = 1'b1;
        d_jal    = 1'b1;
      end
      7'h67: begin
        d_imm = imm_i;
        if (funct3 == 3'd0) begin
          d_op     = ALU_PC4;
          d_lhs    = in_pc;
          d_rhs    = imm_i;
          d_writes = 1'b1;
          d_jalr   = 1'b1;
        end else begin
          d_illegal = 1'b1;
        end
      end
      7'h63: begin
        d_imm    = imm_b;
        d_lhs    = rs1_val;
        d_rhs    = rs2_val;
        d_branch = 1'b1;
        case (funct3)
          3'd0:    d_op = ALU_EQ;
          3'd1:    d_op = ALU_NE;
          3'd4:    d_op = ALU_LT;
          3'd5:    d_op = ALU_GE;
          3'd6:    d_op = ALU_LTU;
          3'd7:    d_op = ALU_GEU;
          default: d_illegal = 1'b1;
        endcase
      end
      7'h03: begin
        d_lhs    = rs1_val;
        d_rhs    = imm_i;
        d_imm    = imm_i;
        d_writes = 1'b1;
        d_load   = 1'b1;
      end
      7'h23: begin
        d_lhs   = rs1_val;
        d_rhs   = imm_s;
        d_imm   = imm_s;
        d_store = 1'b1;
      end
      7'h0F, 7'h73: begin
        d_op = ALU_ADD;
      end
      default: d_illegal = 1'b1;
    endcase
    // an illegal word still occupies a slot, but as a harmless ADD with no side effects
    if (d_illegal) begin
      d_op     = ALU_ADD;
      d_lhs    = 32'd0;
      d_rhs    = 32'd0;
      d_writes = 1'b0;
      d_branch = 1'b0;
      d_jal    = 1'b0;
      d_jalr   = 1'b0;
      d_load   = 1'b0;
      d_store  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_operation <= ALU_ADD;
      out_lhs       <= 32'd0;
      out_rhs       <= 32'd0;
      out_imm       <= 32'd0;
      out_pc        <= 32'd0;
      out_rs2_data  <= 32'd0;
      out_rd        <= 5'd0;
      out_reg_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jal       <= 1'b0;
      out_jalr      <= 1'b0;
      out_load      <= 1'b0;
      out_store     <= 1'b0;
      out_funct3    <= 3'd0;
      out_illegal   <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept && !flush) begin
        out_operation <= d_op;
        out_lhs       <= d_lhs;
        out_rhs       <= d_rhs;
        out_imm       <= d_imm;
        out_pc        <= in_pc;
        out_rs2_data  <= rs2_val;
        out_rd        <= rd;
        out_reg_write <= d_writes && (rd != 5'd0);
        out_branch    <= d_branch;
        out_jal       <= d_jal;
        out_jalr      <= d_jalr;
        out_load      <= d_load;
        out_store     <= d_store;
        out_funct3    <= funct3;
        out_illegal   <= d_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors, a transaction-level reference
// model with a one-entry queue, and per-cycle comparison against the DUT.

module tb_decode_stage;
  import alu_pkg::*;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_instr;
  logic [31:0]    in_pc;
  logic [4:0]     rs1_addr, rs2_addr;
  logic [31:0]    rs1_data, rs2_data;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  alu_operation_t out_operation;
  logic [31:0]    out_lhs, out_rhs, out_imm, out_pc, out_rs2_data;
  logic [4:0]     out_rd;
  logic           out_reg_write, out_branch, out_jal, out_jalr, out_load, out_store;
  logic [2:0]     out_funct3;
  logic           out_illegal;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    alu_operation_t op;
    logic [31:0] lhs, rhs, imm, pc, rs2d;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic rw, br, jal, jalr, ld, st, ill;
    logic chk_ops, chk_imm, chk_rd, chk_f3, chk_rs2;
  } exp_t;

  exp_t q[$];
  bit seen_edge = 0;
  bit hold_pending = 0;
  logic [211:0] prev_snap;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_operation(out_operation), .out_lhs(out_lhs), .out_rhs(out_rhs),
    .out_imm(out_imm), .out_pc(out_pc), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_branch(out_branch), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_load(out_load), .out_store(out_store),
    .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_operation_t reg_op(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_LT;
      3'd3: return ALU_LTU;
      3'd4: return ALU_XOR;
      3'd5: return alt ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decode from the ISA rules, using arithmetic to build immediates
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] a, b, ii, is, ib, iu, ij;
    logic [6:0] f7;
    logic [2:0] f3;
    bit writes;
    s  = ins;
    f7 = ins[31:25];
    f3 = ins[14:12];
    a  = (ins[19:15] == 5'd0) ? 32'd0 : regs[ins[19:15]];
    b  = (ins[24:20] == 5'd0) ? 32'd0 : regs[ins[24:20]];
    ii = s >>> 20;
    is = ((s >>> 25) << 5) + 32'(ins[11:7]);
    ib = ((s >>> 31) << 12) + (32'(ins[7]) << 11) + (32'(ins[30:25]) << 5) + (32'(ins[11:8]) << 1);
    iu = ins & 32'hFFFFF000;
    ij = ((s >>> 31) << 20) + (32'(ins[19:12]) << 12) + (32'(ins[20]) << 11) + (32'(ins[30:21]) << 1);
    e.op = ALU_ADD; e.lhs = 0; e.rhs = 0; e.imm = 0; e.pc = pc; e.rs2d = b;
    e.rd = ins[11:7]; e.f3 = f3;
    e.rw = 0; e.br = 0; e.jal = 0; e.jalr = 0; e.ld = 0; e.st = 0; e.ill = 0;
    e.chk_ops = 0; e.chk_imm = 0; e.chk_rd = 0; e.chk_f3 = 0; e.chk_rs2 = 0;
    writes = 0;
    case (ins[6:0])
      7'h33: begin
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.op = reg_op(f3, f7 == 7'h20);
        e.lhs = a; e.rhs = b; writes = 1; e.chk_ops = 1; e.chk_rd = 1; e.chk_rs2 = 1;
      end
      7'h13: begin
        if (f3 == 3'd1) e.ill = (f7 != 7'h00);
        if (f3 == 3'd5) e.ill = (f7 != 7'h00 && f7 != 7'h20);
        e.op = (f3 == 3'd0) ? ALU_ADD : reg_op(f3, f7 == 7'h20);
        e.lhs = a;
        e.rhs = (f3 == 3'd1 || f3 == 3'd5) ? (ii % 32) : ii;
        e.imm = ii; writes = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1;
      end
      7'h37: begin e.op = ALU_IMM; e.rhs = iu; e.imm = iu; writes = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1; end
      7'h17: begin e.lhs = pc; e.rhs = iu; e.imm = iu; writes = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1; end
      7'h6F: begin e.op = ALU_PC4; e.lhs = pc; e.rhs = ij; e.imm = ij; e.jal = 1; writes = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1; end
      7'h67: begin
        e.ill = (f3 != 3'd0);
        e.op = ALU_PC4; e.lhs = pc; e.rhs = ii; e.imm = ii; e.jalr = 1; writes = 1;
        e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1;
      end
      7'h63: begin
        case (f3)
          3'd0: e.op = ALU_EQ;
          3'd1: e.op = ALU_NE;
          3'd4: e.op = ALU_LT;
          3'd5: e.op = ALU_GE;
          3'd6: e.op = ALU_LTU;
          3'd7: e.op = ALU_GEU;
          default: e.ill = 1;
        endcase
        e.lhs = a; e.rhs = b; e.imm = ib; e.br = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rs2 = 1;
      end
      7'h03: begin e.lhs = a; e.rhs = ii; e.imm = ii; e.ld = 1; writes = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_rd = 1; e.chk_f3 = 1; end
      7'h23: begin e.lhs = a; e.rhs = is; e.imm = is; e.st = 1; e.chk_ops = 1; e.chk_imm = 1; e.chk_f3 = 1; e.chk_rs2 = 1; end
      7'h0F, 7'h73: e.chk_ops = 1;
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.op = ALU_ADD; writes = 0; e.br = 0; e.jal = 0; e.jalr = 0; e.ld = 0; e.st = 0;
      e.chk_ops = 0; e.chk_imm = 0; e.chk_rd = 0; e.chk_f3 = 0; e.chk_rs2 = 0;
    end
    e.rw = writes && (ins[11:7] != 5'd0);
    return e;
  endfunction

  // Pipeline occupancy model: at most one instruction in flight
  always @(posedge clk) begin
    seen_edge <= 1'b1;
    if (reset || flush) begin
      q.delete();
    end else begin
      bit room;
      room = (q.size() == 0) || out_ready;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && room) q.push_back(model(in_instr, in_pc));
    end
  end

  always @(negedge clk) begin
    if (seen_edge) begin
      logic [211:0] snap;
      snap = {out_valid, out_operation, out_lhs, out_rhs, out_imm, out_pc, out_rs2_data,
              out_rd, out_reg_write, out_branch, out_jal, out_jalr, out_load, out_store,
              out_funct3, out_illegal};
      checkOutput("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      checkOutput("rs1_addr", 32'(rs1_addr), 32'(in_instr[19:15]));
      checkOutput("rs2_addr", 32'(rs2_addr), 32'(in_instr[24:20]));
      checkOutput("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        exp_t e;
        e = q[0];
        checkOutput("op", 32'(out_operation), 32'(e.op));
        checkOutput("pc", out_pc, e.pc);
        checkOutput("reg_write", 32'(out_reg_write), 32'(e.rw));
        checkOutput("flags", {26'd0, out_branch, out_jal, out_jalr, out_load, out_store, out_illegal},
                    {26'd0, e.br, e.jal, e.jalr, e.ld, e.st, e.ill});
        if (e.chk_ops) begin
          checkOutput("lhs", out_lhs, e.lhs);
          checkOutput("rhs", out_rhs, e.rhs);
        end
        if (e.chk_imm) checkOutput("imm", out_imm, e.imm);
        if (e.chk_rd)  checkOutput("rd", 32'(out_rd), 32'(e.rd));
        if (e.chk_f3)  checkOutput("funct3", 32'(out_funct3), 32'(e.f3));
        if (e.chk_rs2) checkOutput("rs2_data", out_rs2_data, e.rs2d);
      end
      if (hold_pending) begin
        checks++;
        if (snap !== prev_snap) begin
          errors++;
          $display("[TB] FAIL stall_hold: got %h expected %h", snap, prev_snap);
        end
      end
      prev_snap    = snap;
      hold_pending = out_valid && !out_ready && !flush && !reset;
    end
  end

  // Present one instruction and wait (bounded) for the handshake to complete
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    bit ok;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no transfer expected transfer of %h", instr);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] vecs [16] = '{
    32'hFFC0A203, 32'h0020A423, 32'h4030D313, 32'h00000013,
    32'h000100E7, 32'h00001397, 32'h0020D463, 32'h00000073,
    32'h0000000F, 32'h022081B3, 32'h0020A463, 32'h40109313,
    32'h00500090, 32'h000110E7, 32'h4020D1B3, 32'h4020C1B3
  };

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
    regs[0] = 32'hDEADBEEF;
    regs[1] = 32'd10;
    regs[2] = 32'd3;
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_op", 32'(out_operation), 32'(ALU_ADD));
    checkOutput("reset_lhs", out_lhs, 32'd0);
    checkOutput("reset_pc", out_pc, 32'd0);
    checkOutput("reset_flags", {26'd0, out_reg_write, out_branch, out_jal, out_load, out_store, out_illegal}, 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(32'h00500093, 32'h0);
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_op", 32'(out_operation), 32'(ALU_ADD));
    checkOutput("addi_lhs", out_lhs, 32'd0);
    checkOutput("addi_rhs", out_rhs, 32'd5);
    checkOutput("addi_rd", 32'(out_rd), 32'd1);
    checkOutput("addi_rw", 32'(out_reg_write), 32'd1);

    applyStimulus(32'h402081B3, 32'h4);
    checkOutput("sub_op", 32'(out_operation), 32'(ALU_SUB));
    checkOutput("sub_lhs", out_lhs, 32'd10);
    checkOutput("sub_rhs", out_rhs, 32'd3);
    checkOutput("sub_rd", 32'(out_rd), 32'd3);
    applyStimulus(32'h002081B3, 32'h8);
    checkOutput("add_op", 32'(out_operation), 32'(ALU_ADD));

    applyStimulus(32'h00208463, 32'hC);
    checkOutput("beq_op", 32'(out_operation), 32'(ALU_EQ));
    checkOutput("beq_imm", out_imm, 32'd8);
    checkOutput("beq_branch", 32'(out_branch), 32'd1);
    checkOutput("beq_rw", 32'(out_reg_write), 32'd0);

    applyStimulus(32'h123452B7, 32'h10);
    checkOutput("lui_op", 32'(out_operation), 32'(ALU_IMM));
    checkOutput("lui_rhs", out_rhs, 32'h12345000);
    applyStimulus(32'h010000EF, 32'h100);
    checkOutput("jal_op", 32'(out_operation), 32'(ALU_PC4));
    checkOutput("jal_lhs", out_lhs, 32'h100);
    checkOutput("jal_imm", out_imm, 32'd16);
    checkOutput("jal_flag", 32'(out_jal), 32'd1);

    // stall with a pending instruction, then release into back-to-back transfers
    applyStimulus(32'h0030F213, 32'h180);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00108293;
    in_pc     = 32'h184;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_pc", out_pc, 32'h180);
    end
    out_ready = 1'b1;
    applyStimulus(32'h00108293, 32'h184);
    checkOutput("release_pc", out_pc, 32'h184);
    applyStimulus(32'h00208313, 32'h188);
    checkOutput("b2b_pc", out_pc, 32'h188);
    checkOutput("b2b_valid", 32'(out_valid), 32'd1);

    // flush the registered op while another is being offered
    applyStimulus(32'h00310393, 32'h300);
    in_valid = 1'b1;
    in_instr = 32'h00410413;
    in_pc    = 32'h304;
    flush    = 1'b1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", 32'(out_valid), 32'd0);

    applyStimulus(32'hFFFFFFFF, 32'h400);
    checkOutput("ill_flag", 32'(out_illegal), 32'd1);
    checkOutput("ill_rw", 32'(out_reg_write), 32'd0);
    checkOutput("ill_op", 32'(out_operation), 32'(ALU_ADD));

    // remaining encodings, with an occasional one-cycle stall on a pending input
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 2) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = vecs[i];
        in_pc     = 32'h200 + 32'(i) * 4;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      applyStimulus(vecs[i], 32'h200 + 32'(i) * 4);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
